// File: rtl/mem_access_pkg.sv
// Shared definitions for the memory-access pipeline stage: FSM encoding and
// the default bus timeout.
package mem_access_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  localparam int DEFAULT_TIMEOUT = 16;

endpackage

// File: rtl/mem_access_mem_wb_reg.sv
// MEM/WB pipeline register: captures a full result on load, or clears the
// write-back enables on bubble while holding the data fields.
module mem_wb_reg (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        bubble,
  input  logic [31:0] data_in,
  input  logic [31:0] alu_in,
  input  logic [3:0]  rd_in,
  input  logic        w_en_in,
  input  logic        mem_enable_in,
  output logic [31:0] data_out,
  output logic [31:0] alu_out,
  output logic [3:0]  rd_out,
  output logic        w_en_out,
  output logic        mem_enable_out
);

  always_ff @(posedge clk) begin
    if (reset) begin
      data_out       <= '0;
      alu_out        <= '0;
      rd_out         <= '0;
      w_en_out       <= 1'b0;
      mem_enable_out <= 1'b0;
    end else if (load) begin
      data_out       <= data_in;
      alu_out        <= alu_in;
      rd_out         <= rd_in;
      w_en_out       <= w_en_in;
      mem_enable_out <= mem_enable_in;
    end else if (bubble) begin
      w_en_out       <= 1'b0;
      mem_enable_out <= 1'b0;
    end
  end

endmodule

// File: rtl/mem_access.sv
// Memory-access pipeline stage: passes ALU results through, or runs a single
// load/store on the data bus, stalling upstream until ack or timeout.
module mem_access
  import mem_access_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_in,
  input  logic [31:0] alu_in,
  input  logic [31:0] store_data,
  input  logic [3:0]  Rd_in,
  input  logic        w_en_in,
  input  logic        mem_read,
  input  logic        mem_write,
  output logic        stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [31:0] data_out,
  output logic [31:0] alu_out,
  output logic [3:0]  Rd_out,
  output logic        w_en_out,
  output logic        mem_enable_out,
  output logic        fault,
  output logic        bus_error
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_t            state, state_next;
  logic [CNT_W-1:0]  count;
  logic [31:0]       addr_q, wdata_q;
  logic [3:0]        rd_q;
  logic              wen_q, is_load_q;

  logic              mem_op, aligned, timed_out;
  logic              latch_en, fault_next, berr_next;
  logic              wb_load, wb_bubble, wb_wen, wb_men;
  logic [31:0]       wb_alu;
  logic [3:0]        wb_rd;

  assign mem_op    = mem_read | mem_write;
  assign aligned   = (alu_in[1:0] == 2'b00);
  assign timed_out = (count == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    latch_en   = 1'b0;
    fault_next = 1'b0;
    berr_next  = 1'b0;
    wb_load    = 1'b0;
    wb_bubble  = 1'b0;
    wb_alu     = alu_in;
    wb_rd      = Rd_in;
    wb_wen     = w_en_in;
    wb_men     = 1'b0;
    case (state)
      IDLE: begin
        if (!valid_in) begin
          wb_bubble = 1'b1;
        end else if (!mem_op) begin
          wb_load = 1'b1;
        end else if (aligned) begin
          latch_en   = 1'b1;
          wb_bubble  = 1'b1;
          state_next = ACCESS;
        end else begin
          fault_next = 1'b1;
          wb_bubble  = 1'b1;
        end
      end
      ACCESS: begin
        // Ack takes precedence over an expiring timeout on the same cycle.
        if (mem_ack) begin
          wb_load    = 1'b1;
          wb_alu     = addr_q;
          wb_rd      = rd_q;
          wb_wen     = wen_q;
          wb_men     = is_load_q;
          state_next = IDLE;
        end else if (timed_out) begin
          wb_bubble  = 1'b1;
          berr_next  = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rd_q      <= '0;
      wen_q     <= 1'b0;
      is_load_q <= 1'b0;
      fault     <= 1'b0;
      bus_error <= 1'b0;
    end else begin
      fault     <= fault_next;
      bus_error <= berr_next;
      if (latch_en) begin
        count     <= '0;
        addr_q    <= alu_in;
        wdata_q   <= store_data;
        rd_q      <= Rd_in;
        wen_q     <= w_en_in;
        is_load_q <= mem_read;
      end else if (state == ACCESS) begin
        count <= count + 1'b1;
      end
    end
  end

  assign stall     = (state == ACCESS);
  assign mem_req   = (state == ACCESS);
  assign mem_we    = (state == ACCESS) && !is_load_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

  mem_wb_reg u_mem_wb_reg (
    .clk            (clk),
    .reset          (reset),
    .load           (wb_load),
    .bubble         (wb_bubble),
    .data_in        (mem_rdata),
    .alu_in         (wb_alu),
    .rd_in          (wb_rd),
    .w_en_in        (wb_wen),
    .mem_enable_in  (wb_men),
    .data_out       (data_out),
    .alu_out        (alu_out),
    .rd_out         (Rd_out),
    .w_en_out       (w_en_out),
    .mem_enable_out (mem_enable_out)
  );

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: ALU pass-through, load, store, misaligned,
// timeout, ack-at-limit and reset-during-access scenarios.
module tb_mem_access;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_in;
  logic [31:0] alu_in, store_data;
  logic [3:0]  Rd_in;
  logic        w_en_in, mem_read, mem_write;
  logic        stall, mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [31:0] data_out, alu_out;
  logic [3:0]  Rd_out;
  logic        w_en_out, mem_enable_out, fault, bus_error;

  int errors = 0;
  int checks = 0;
  int n;

  mem_access #(.TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .alu_in(alu_in),
    .store_data(store_data), .Rd_in(Rd_in), .w_en_in(w_en_in),
    .mem_read(mem_read), .mem_write(mem_write), .stall(stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .data_out(data_out), .alu_out(alu_out), .Rd_out(Rd_out),
    .w_en_out(w_en_out), .mem_enable_out(mem_enable_out),
    .fault(fault), .bus_error(bus_error)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic rd, input logic wr, input logic [31:0] addr,
                       input logic [3:0] dst, input logic wen, input logic [31:0] sd);
    valid_in = 1'b1; mem_read = rd; mem_write = wr; alu_in = addr;
    Rd_in = dst; w_en_in = wen; store_data = sd;
    step();
    valid_in = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
  endtask

  initial begin
    reset = 1'b1; valid_in = 1'b0; alu_in = '0; store_data = '0; Rd_in = '0;
    w_en_in = 1'b0; mem_read = 1'b0; mem_write = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
    step(); step();
    chk("rst_stall", {31'd0, stall}, 0);
    chk("rst_req", {31'd0, mem_req}, 0);
    chk("rst_wen", {31'd0, w_en_out}, 0);
    chk("rst_alu", alu_out, 0);
    chk("rst_fault", {31'd0, fault}, 0);
    chk("rst_berr", {31'd0, bus_error}, 0);
    reset = 1'b0;

    // ALU pass-through, then a bubble
    issue(1'b0, 1'b0, 32'h1234, 4'd3, 1'b1, 32'h0);
    chk("alu_alu_out", alu_out, 32'h1234);
    chk("alu_rd_out", {28'd0, Rd_out}, 3);
    chk("alu_wen", {31'd0, w_en_out}, 1);
    chk("alu_men", {31'd0, mem_enable_out}, 0);
    chk("alu_stall", {31'd0, stall}, 0);
    step();
    chk("bubble_wen", {31'd0, w_en_out}, 0);
    chk("bubble_alu_hold", alu_out, 32'h1234);

    // Load acked on the 3rd ACCESS cycle
    issue(1'b1, 1'b0, 32'h100, 4'd5, 1'b1, 32'h0);
    chk("ld_c1_stall", {31'd0, stall}, 1);
    chk("ld_c1_req", {31'd0, mem_req}, 1);
    chk("ld_c1_we", {31'd0, mem_we}, 0);
    chk("ld_c1_addr", mem_addr, 32'h100);
    chk("ld_c1_wen", {31'd0, w_en_out}, 0);
    step();
    chk("ld_c2_stall", {31'd0, stall}, 1);
    step();
    chk("ld_c3_stall", {31'd0, stall}, 1);
    chk("ld_c3_addr", mem_addr, 32'h100);
    mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
    step();
    mem_ack = 1'b0;
    chk("ld_done_stall", {31'd0, stall}, 0);
    chk("ld_data", data_out, 32'hDEADBEEF);
    chk("ld_men", {31'd0, mem_enable_out}, 1);
    chk("ld_rd", {28'd0, Rd_out}, 5);
    chk("ld_wen", {31'd0, w_en_out}, 1);
    chk("ld_alu", alu_out, 32'h100);

    // Store with immediate ack
    issue(1'b0, 1'b1, 32'h200, 4'd2, 1'b0, 32'hCAFEF00D);
    chk("st_req", {31'd0, mem_req}, 1);
    chk("st_we", {31'd0, mem_we}, 1);
    chk("st_wdata", mem_wdata, 32'hCAFEF00D);
    chk("st_addr", mem_addr, 32'h200);
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    chk("st_done_req", {31'd0, mem_req}, 0);
    chk("st_done_we", {31'd0, mem_we}, 0);
    chk("st_men", {31'd0, mem_enable_out}, 0);
    chk("st_wen", {31'd0, w_en_out}, 0);

    // Misaligned load
    issue(1'b1, 1'b0, 32'h102, 4'd7, 1'b1, 32'h0);
    chk("mis_req", {31'd0, mem_req}, 0);
    chk("mis_fault", {31'd0, fault}, 1);
    chk("mis_wen", {31'd0, w_en_out}, 0);
    step();
    chk("mis_fault_pulse", {31'd0, fault}, 0);

    // Read+write together behaves as a load
    issue(1'b1, 1'b1, 32'h300, 4'd4, 1'b1, 32'h77);
    chk("rw_we", {31'd0, mem_we}, 0);
    mem_ack = 1'b1; mem_rdata = 32'h11112222;
    step();
    mem_ack = 1'b0;
    chk("rw_data", data_out, 32'h11112222);
    chk("rw_men", {31'd0, mem_enable_out}, 1);

    // Timeout with no ack
    issue(1'b1, 1'b0, 32'h400, 4'd9, 1'b1, 32'h0);
    n = 0;
    while (mem_req === 1'b1 && n < 40) begin
      n++;
      step();
    end
    chk("to_req_cycles", n, 16);
    chk("to_berr", {31'd0, bus_error}, 1);
    chk("to_wen", {31'd0, w_en_out}, 0);
    step();
    chk("to_berr_pulse", {31'd0, bus_error}, 0);

    // Ack on the 16th ACCESS cycle completes normally
    issue(1'b1, 1'b0, 32'h404, 4'd10, 1'b1, 32'h0);
    repeat (15) step();
    chk("ack16_req", {31'd0, mem_req}, 1);
    mem_ack = 1'b1; mem_rdata = 32'h0BADF00D;
    step();
    mem_ack = 1'b0;
    chk("ack16_berr", {31'd0, bus_error}, 0);
    chk("ack16_data", data_out, 32'h0BADF00D);
    chk("ack16_wen", {31'd0, w_en_out}, 1);
    chk("ack16_stall", {31'd0, stall}, 0);

    // Reset on the 2nd ACCESS cycle, then a stray ack
    issue(1'b1, 1'b0, 32'h500, 4'd6, 1'b1, 32'h0);
    step();
    chk("rsta_stall_pre", {31'd0, stall}, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rsta_stall", {31'd0, stall}, 0);
    chk("rsta_req", {31'd0, mem_req}, 0);
    chk("rsta_addr", mem_addr, 0);
    chk("rsta_data", data_out, 0);
    chk("rsta_rd", {28'd0, Rd_out}, 0);
    chk("rsta_wen", {31'd0, w_en_out}, 0);
    mem_ack = 1'b1; mem_rdata = 32'h55;
    step();
    mem_ack = 1'b0;
    chk("idle_ack_data", data_out, 0);
    chk("idle_ack_men", {31'd0, mem_enable_out}, 0);
    chk("idle_ack_stall", {31'd0, stall}, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_access.md
MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16, meaning the maximum number of ACCESS cycles to wait for mem_ack before aborting.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port valid_in  input  1  the execute stage presents an instruction this cycle.
REQ-005 SHALL have port alu_in  input  32  ALU result, used as the memory address for loads and stores.
REQ-006 SHALL have port store_data  input  32  data to write on a store.
REQ-007 SHALL have port Rd_in  input  4  destination register number.
REQ-008 SHALL have port w_en_in  input  1  register-write request from execute.
REQ-009 SHALL have port mem_read  input  1  the instruction is a load.
REQ-010 SHALL have port mem_write  input  1  the instruction is a store.
REQ-011 SHALL have port stall  output  1  upstream holds its outputs while this is high.
REQ-012 SHALL have ports mem_req (output 1), mem_we (output 1), mem_addr (output 32), mem_wdata (output 32): the data-memory request bus.
REQ-013 SHALL have ports mem_ack (input 1), mem_rdata (input 32): memory completion and load data.
REQ-014 SHALL have ports data_out (output 32), alu_out (output 32), Rd_out (output 4), w_en_out (output 1), mem_enable_out (output 1), which drive write_back's data_in, alu_in, Rd_in, w_en and mem_enable.
REQ-015 SHALL have ports fault (output 1, misaligned-access pulse) and bus_error (output 1, timeout pulse).

Function
REQ-016 SHALL implement the FSM states IDLE and ACCESS; all outputs to write_back are registered.
REQ-017 In IDLE, valid_in with neither mem_read nor mem_write SHALL update alu_out, Rd_out and w_en_out from the inputs on the next edge, with mem_enable_out=0 (latency 1).
REQ-018 In IDLE, valid_in=0 SHALL produce a bubble on the next edge: w_en_out=0, mem_enable_out=0.
REQ-019 In IDLE, a valid load or store with alu_in[1:0]==0 SHALL latch address, store_data, Rd_in, w_en_in and the op type, then enter ACCESS on the next edge, while issuing a bubble to write_back.
REQ-020 In IDLE, a valid load or store with alu_in[1:0]!=0 SHALL issue no bus request, pulse fault for one cycle, and force w_en_out=0 on the next edge.
REQ-021 If mem_read and mem_write are both set, SHALL treat the instruction as a load.
REQ-022 In ACCESS, SHALL hold mem_req=1, hold mem_we=1 for a store, and keep mem_addr and mem_wdata constant; mem_req SHALL be 0 in IDLE.
REQ-023 stall SHALL equal (state==ACCESS); valid_in SHALL be ignored in ACCESS.
REQ-024 In ACCESS, SHALL keep an internal counter that clears on ACCESS entry and increments every ACCESS cycle.
REQ-025 On an ACCESS cycle with mem_ack=1, on the next edge SHALL return to IDLE and update the write_back outputs, latency 1 after ack.
- Load: data_out=mem_rdata, mem_enable_out=1, w_en_out=latched w_en.
- Store: mem_enable_out=0, w_en_out=latched w_en.
REQ-026 If the counter reaches TIMEOUT-1 with mem_ack=0, on the next edge SHALL return to IDLE, pulse bus_error for one cycle, and force w_en_out=0.
REQ-027 If mem_ack and timeout coincide, mem_ack SHALL win.
REQ-028 mem_ack arriving in IDLE SHALL be ignored.
REQ-029 alu_out and Rd_out SHALL carry the latched values for memory ops, so a load result goes to the correct Rd.

Reset
REQ-030 reset SHALL force IDLE, zero the counter, and set all outputs to 0 (including stall, mem_req, fault and bus_error) on the next edge.
REQ-031 reset during ACCESS SHALL abandon the access, with mem_req=0 the cycle after the edge and no write_back update.
REQ-032 reset SHALL take priority over every other input.

Structure
REQ-033 A shared package SHALL hold the FSM state encoding (IDLE=0, ACCESS=1) and the default TIMEOUT constant.
REQ-034 The MEM/WB output register SHALL be one sub-module, mem_wb_reg, with load-enable and bubble inputs.

Verification
REQ-035 ALU op: valid_in=1, alu_in=0x1234, Rd_in=3, w_en_in=1 -> next cycle alu_out=0x1234, Rd_out=3, w_en_out=1, mem_enable_out=0, stall=0.
REQ-036 Load: alu_in=0x100, Rd_in=5, memory acks after 3 ACCESS cycles with 0xDEADBEEF -> stall high 3 cycles, mem_addr=0x100, then data_out=0xDEADBEEF, mem_enable_out=1, Rd_out=5.
REQ-037 Store: alu_in=0x200, store_data=0xCAFEF00D, immediate ack -> mem_we=1 and mem_wdata=0xCAFEF00D for 1 cycle, mem_enable_out=0.
REQ-038 Misaligned load to 0x102 -> no mem_req, fault pulses 1 cycle, w_en_out=0.
REQ-039 Timeout: no ack, TIMEOUT=16 -> mem_req high exactly 16 cycles, bus_error pulse, w_en_out=0; also ack on cycle 16 -> normal completion with no bus_error.
REQ-040 Reset asserted on the 2nd ACCESS cycle -> all outputs 0 next cycle, state IDLE, and a later ack has no effect.
